// File: rtl/uart_tx_fifo_if.sv
// Valid/ready push channel into the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit before stop.
// States: IDLE line high | START start bit out | DATA data bits out | PARITY parity out | STOP stop bit out.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DATA_BITS       = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    uart_tx_fifo_if.slave            push_if,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count_o
);
    localparam int PTR_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic parity_q, parity_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] rd_data;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d, busy_q;

    // Occupancy, full and empty come only from registered pointers, so a
    // same-cycle pop never frees space for a push and a new byte is never popped early.
    assign fifo_count_o  = wr_ptr_q - rd_ptr_q;
    assign full          = (fifo_count_o == PTR_W'(DEPTH));
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign push          = push_if.valid && !full;
    assign push_if.ready = !full;
    assign rd_data       = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
    assign wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d      = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    assign count_d       = wr_ptr_d - rd_ptr_d;
    assign tx_o          = tx_q;
    assign busy_o        = busy_q;

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= push_if.data;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (enable_i) begin
            case (state_q)
                S_IDLE, S_STOP: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        tx_d    = 1'b0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^rd_data;
`endif
                    end
                end
                S_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_ONE;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q < CNT_W'(DATA_BITS)) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
`endif
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != S_IDLE) || (count_d != '0);
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter: the transmit end of the serial link whose receive side feeds the brainfuck processor's rx input.
- Accepts bytes through a valid/ready push interface and stores them in an internal FIFO.
- Serialises the stored bytes LSB-first on tx. Bit timing comes from the shared bit-period enable pulse, the same counter-generated tick used by the processor UART.
- Used by on-board test and loader logic to stream programs and input bytes into the core.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth; default gives 16 entries.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  main clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  bit-period tick, one clk cycle wide; tx changes only on cycles where enable=1.
- data_in  input  DATA_BITS  byte to enqueue.
- data_valid  input  1  push request.
- ready  output  1  FIFO not full; a push is accepted when data_valid and ready are both 1.
- tx  output  1  serial line; idles high.
- busy  output  1  1 while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy, 0..2^FIFO_DEPTH_LOG2.

Behaviour:
- Reset values:
  - tx=1, busy=0, ready=1, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; bit counter=0; shift register=0.
- FIFO:
  - Circular buffer with read and write pointers of FIFO_DEPTH_LOG2+1 bits, so full and empty are distinguishable.
  - ready = !full, derived from registered pointers.
  - A push while full is dropped; no pointer or data change.
  - A byte pushed into an empty FIFO becomes poppable on the next cycle, never the same cycle.
  - A push and a pop in the same cycle are both honoured; fifo_count is unchanged.
  - When full, a same-cycle pop does not make ready=1 that cycle; the push is rejected.
- State machine. All transitions occur only on cycles with enable=1; on other cycles the state holds.
  - IDLE: tx=1. If the FIFO is non-empty: pop into the shift register, drive tx=0, go to START.
  - START: drive tx=shift[0], shift right, set bit counter=1, go to DATA.
  - DATA: if bit counter<DATA_BITS, drive tx=shift[0], shift, and increment the counter. Otherwise drive tx=1 and go to STOP (or PARITY when the optional feature is enabled).
  - STOP: tx is held at 1 for the full tick. Then:
    - FIFO non-empty: pop, drive tx=0, go to START. Back-to-back frames have no idle gap.
    - FIFO empty: go to IDLE.
- Frame length: exactly 10 enable periods (1 start, 8 data, 1 stop) with DATA_BITS=8.
- Latency: the first tx falling edge occurs on the first enable at least one cycle after the push into an empty, idle block.
- busy = (state!=IDLE) || fifo_count!=0, registered.
- enable held constantly high: one bit per clk cycle; this mode is legal and is used for simulation speed.
- Reset mid-frame: on the next edge tx=1, state=IDLE, and the FIFO is flushed. The partially sent byte is lost; no stop bit is appended.
- Pushes continue to be accepted during transmission whenever ready=1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - PARITY drives tx = XOR of the frame's data bits, i.e. even parity, computed when the byte is popped.
  - Frame length is 11 enable periods.
- Undefined: no PARITY state; DATA goes directly to STOP; frame length is 10 periods. The parity logic is not synthesised.

Test Plan:
- Single byte, enable every 12 cycles: push 0x55 → tx sequence per tick is 0,1,0,1,0,1,0,1,0,1 then idle 1. busy=1 from the cycle after the push until the end of the stop bit.
- Back-to-back: push 0x41 and 0x42 on consecutive cycles → the stop bit of 0x41 (tx=1, one tick) is directly followed by the start bit of 0x42. Total of 20 ticks; fifo_count goes 1,2 then drains to 0.
- Full FIFO with enable held 0: push 17 bytes 0x00..0x10 → ready=0 after 16 pushes, fifo_count=16, 0x10 dropped. After enable is released, exactly 0x00..0x0F are transmitted in order.
- Simultaneous push/pop: with 3 entries queued, push on the cycle of a pop → fifo_count stays 3; order is preserved.
- Reset mid-frame: assert reset during data bit 3 of 0xF0 with 4 bytes queued → next cycle tx=1, fifo_count=0, ready=1, busy=0. No further frames are sent.
- With UART_TX_PARITY_EN: push 0x07 → parity bit 1 before the stop bit. Push 0x03 → parity bit 0. Each frame is 11 ticks.
